filter_fir_engine: RTL and testbench
====================================

# filter_fir_engine

Downstream consumer of `filter_storage`: on each new-sample strobe it walks the most recent TAPS samples in the 512-entry circular sample buffer through the storage read port. It multiplies each sample by a Q1.15 coefficient fetched from an external coefficient ROM and accumulates the products. It emits one rounded, saturated 16-bit filter output per accepted sample. It sits between the sample-write path, which writes `filter_storage` and raises `smp_valid`, and the output/DAC interface.

## Interface
- `TAPS`, 32: number of filter taps, 2..256.
- `AW`, 9: storage pointer width (512 entries).
- `DW`, 16: sample, coefficient and output width (signed two's complement).
- `CAW`, 8: coefficient address width, with 2^CAW ≥ TAPS.
- `ACCW`, 40: accumulator width.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `smp_valid`  in  1  one-cycle strobe: the newest sample has been written at `smp_ptr`.
- `smp_ptr`  in  AW  storage address of the newest sample.
- `rden`  out  1  storage read enable.
- `rdptr`  out  AW  storage read address.
- `rddata`  in  DW  storage read data, valid one cycle after `rden`.
- `coef_addr`  out  CAW  coefficient index k.
- `coef_data`  in  DW  coefficient, Q1.15, valid one cycle after `coef_addr`.
- `busy`  out  1  a computation is in progress.
- `out_valid`  out  1  one-cycle pulse: `out_data` is valid.
- `out_data`  out  DW  filter result, Q1.15; held until the next `out_valid`.
- `overrun`  out  1  one-cycle pulse: `smp_valid` arrived while `busy`.

## Operation
- **FSM states:** IDLE, READ, DRAIN, ROUND, OUT.
- **IDLE:**
  - `smp_valid` latches `base = smp_ptr`, clears `k` and the accumulator, and moves to READ.
- **READ:**
  - Drives `rden=1`, `rdptr = (base − k) mod 2^AW` and `coef_addr = k`.
  - Increments `k` every cycle.
  - When `k = TAPS−1` has been issued, moves to DRAIN.
- **DRAIN:** 2 cycles, covering the read latency plus the product register.
- **ROUND:**
  - Computes `(acc + 2^14) >>> 15`.
  - Saturates the result to [−32768, 32767].
  - Registers the result into `out_data`.
- **OUT:** `out_valid=1` for one cycle, then returns to IDLE.
- **MAC pipeline:**
  - Stage 1 registers the signed 16×16 product (32-bit).
  - Stage 2 sign-extends the product to ACCW and adds it to `acc`.
  - There is no intermediate saturation; ACCW=40 guarantees no overflow for TAPS ≤ 256.
- **Overrun:**
  - `smp_valid` in any state other than IDLE is ignored and `overrun` pulses in the following cycle.
  - The computation in flight is unaffected.
- **Wrap-around:** `rdptr` wraps modulo 512 (e.g. base 3: 3, 2, 1, 0, 511, …).
- **Reset:**
  - Reset in any state forces IDLE and clears `acc`, `k` and `base`.
  - All outputs go to 0 (`rden`, `rdptr`, `coef_addr`, `busy`, `out_valid`, `out_data`, `overrun`) on the next edge.
  - A computation cut short by reset produces no `out_valid`.
  - Reset has priority over a simultaneous `smp_valid`.

## Timing
- `smp_valid` is sampled in cycle 0.
- `rden` is high in cycles 1..TAPS.
- Product k is registered at the end of cycle k+2; accumulate k happens at the end of cycle k+3.
- The final accumulate is at the end of cycle TAPS+2.
- ROUND occupies cycle TAPS+3.
- `out_valid` is high in cycle TAPS+4 (36 for TAPS=32).
- `busy` is high in cycles 1..TAPS+3 and low in the OUT cycle.
- A `smp_valid` in the OUT cycle is an overrun. The earliest accepted next strobe is cycle TAPS+5, giving a throughput of one result per TAPS+5 cycles.
- `rdptr` and `coef_addr` are registered outputs; they hold their last value when `rden=0`.

## Structure
- **Package `filter_pkg`:**
  - AW, DW, TAPS, CAW and ACCW defaults.
  - The FSM state enum.
  - Rounding constant `RND = 2^14` and shift `FRAC = 15`.
  - SAT_MAX/SAT_MIN.
- **Sub-module `filter_mac`:**
  - Registered multiply, accumulate with a clear input, and round/saturate output.
  - The top level contains the FSM, the tap counter and address generation.

## Test plan
- **Impulse:** storage[100]=0x4000, others 0; coef[5]=0x1234, others 0; `smp_ptr`=105 → `out_data`=0x091A with `out_valid` in cycle 36.
- **Positive saturation:** all samples 0x7FFF, all coefficients 0x7FFF → `out_data`=0x7FFF.
- **Negative saturation:** samples 0x8000, coefficients 0x7FFF → `out_data`=0x8000.
- **Wrap-around:** `smp_ptr`=3 → `rdptr` sequence 3, 2, 1, 0, 511, …, 484 over 32 cycles, with `coef_addr` 0..31.
- **Overrun:** second `smp_valid` in cycle 10 → `overrun` pulse in cycle 11, exactly one `out_valid` (cycle 36) with the first sample's result.
- **Reset mid-operation:** `rst` in cycle 15 → all outputs 0 in cycle 16 and no `out_valid`; a new `smp_valid` after reset yields the correct result 36 cycles later.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared constants, default geometry and FSM state type for the FIR engine.
package filter_pkg;

  localparam int unsigned DEF_TAPS = 32;
  localparam int unsigned DEF_AW   = 9;
  localparam int unsigned DEF_DW   = 16;
  localparam int unsigned DEF_CAW  = 8;
  localparam int unsigned DEF_ACCW = 40;

  localparam int RND     = 1 << 14;
  localparam int FRAC    = 15;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StRound,
    StOut
  } fir_state_e;

endpackage

// File: rtl/filter_mac.sv
// Two-stage multiply-accumulate with a synchronous clear, plus round/saturate to Q1.15.
module filter_mac
  import filter_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned ACCW = DEF_ACCW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          issue,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] coef,
  input  logic          round,
  output logic [DW-1:0] result
);

  localparam logic signed [ACCW-1:0] RndA   = ACCW'(RND);
  localparam logic signed [ACCW-1:0] SatMax = ACCW'(SAT_MAX);
  localparam logic signed [ACCW-1:0] SatMin = ACCW'(SAT_MIN);

  logic                   data_vld_q;
  logic                   prod_vld_q;
  logic signed [2*DW-1:0] prod_q, prod_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] rnd_sum, shifted;
  logic        [DW-1:0]   result_q, result_d;

  always_comb begin
    prod_d   = $signed({{DW{sample[DW-1]}}, sample}) * $signed({{DW{coef[DW-1]}}, coef});
    acc_d    = acc_q + {{(ACCW-2*DW){prod_q[2*DW-1]}}, prod_q};
    rnd_sum  = acc_q + RndA;
    shifted  = rnd_sum >>> FRAC;
    if (shifted > SatMax) begin
      result_d = DW'(SAT_MAX);
    end else if (shifted < SatMin) begin
      result_d = DW'(SAT_MIN);
    end else begin
      result_d = shifted[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else begin
      // Storage and coefficient data arrive one cycle after the address is issued.
      data_vld_q <= issue;
      if (clear) begin
        prod_vld_q <= 1'b0;
        acc_q      <= '0;
      end else begin
        prod_vld_q <= data_vld_q;
        if (data_vld_q) prod_q <= prod_d;
        if (prod_vld_q) acc_q <= acc_d;
      end
      if (round) result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/filter_fir_engine.sv
// FIR sequencer: walks the newest TAPS samples backwards through storage and feeds the MAC.
module filter_fir_engine
  import filter_pkg::*;
#(
  parameter int unsigned TAPS = DEF_TAPS,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned CAW  = DEF_CAW,
  parameter int unsigned ACCW = DEF_ACCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           smp_valid,
  input  logic [AW-1:0]  smp_ptr,
  output logic           rden,
  output logic [AW-1:0]  rdptr,
  input  logic [DW-1:0]  rddata,
  output logic [CAW-1:0] coef_addr,
  input  logic [DW-1:0]  coef_data,
  output logic           busy,
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  output logic           overrun
);

  localparam logic [CAW-1:0] LastTap = CAW'(TAPS - 1);

  fir_state_e     state_q, state_d;
  logic [AW-1:0]  base_q, base_d;
  logic [CAW-1:0] k_q, k_d, k_inc;
  logic           drain_q, drain_d;
  logic [AW-1:0]  rdptr_q, rdptr_d;
  logic [CAW-1:0] coef_addr_q, coef_addr_d;
  logic           overrun_q, overrun_d;
  logic           mac_clear, mac_round;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    k_d         = k_q;
    drain_d     = drain_q;
    rdptr_d     = rdptr_q;
    coef_addr_d = coef_addr_q;
    mac_clear   = 1'b0;
    mac_round   = 1'b0;
    k_inc       = k_q + 1'b1;
    overrun_d   = smp_valid && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (smp_valid) begin
          base_d      = smp_ptr;
          k_d         = '0;
          rdptr_d     = smp_ptr;
          coef_addr_d = '0;
          mac_clear   = 1'b1;
          state_d     = StRead;
        end
      end
      StRead: begin
        k_d = k_inc;
        if (k_q == LastTap) begin
          drain_d = 1'b0;
          state_d = StDrain;
        end else begin
          // Addresses are registered, so the next tap is prepared one cycle ahead.
          rdptr_d     = base_q - AW'(k_inc);
          coef_addr_d = k_inc;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) state_d = StRound;
      end
      StRound: begin
        mac_round = 1'b1;
        state_d   = StOut;
      end
      StOut: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      k_q         <= '0;
      drain_q     <= 1'b0;
      rdptr_q     <= '0;
      coef_addr_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      rdptr_q     <= rdptr_d;
      coef_addr_q <= coef_addr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rden      = (state_q == StRead);
  assign busy      = (state_q == StRead) || (state_q == StDrain) || (state_q == StRound);
  assign out_valid = (state_q == StOut);
  assign rdptr     = rdptr_q;
  assign coef_addr = coef_addr_q;
  assign overrun   = overrun_q;

  filter_mac #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .issue  (rden),
    .sample (rddata),
    .coef   (coef_data),
    .round  (mac_round),
    .result (out_data)
  );

endmodule

// File: tb/tb_filter_fir_engine.sv
// Directed, table-driven bench for filter_fir_engine with storage and coefficient ROM models.
module tb_filter_fir_engine;

  localparam int TAPS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        smp_valid;
  logic [8:0]  smp_ptr;
  logic        rden;
  logic [8:0]  rdptr;
  logic [15:0] rddata;
  logic [7:0]  coef_addr;
  logic [15:0] coef_data;
  logic        busy;
  logic        out_valid;
  logic [15:0] out_data;
  logic        overrun;

  logic [15:0] mem [512];
  logic [15:0] rom [256];

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    string       name;
    logic [8:0]  ptr;
    int          sidx;
    logic [15:0] sval;
    int          cidx;
    logic [15:0] cval;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  filter_fir_engine dut (
    .clk       (clk),
    .rst       (rst),
    .smp_valid (smp_valid),
    .smp_ptr   (smp_ptr),
    .rden      (rden),
    .rdptr     (rdptr),
    .rddata    (rddata),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rden) rddata <= mem[rdptr];
    coef_data <= rom[coef_addr];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic load(input int sidx, input logic [15:0] sval, input int cidx,
                      input logic [15:0] cval);
    for (int i = 0; i < 512; i++) mem[i] = (sidx < 0 || i == sidx) ? sval : 16'h0000;
    for (int i = 0; i < 256; i++) rom[i] = (cidx < 0 || i == cidx) ? cval : 16'h0000;
  endtask

  // Strobe at cycle 0, then observe cycles 1..40 against a per-cycle model.
  task automatic run(input string nm, input logic [8:0] ptr, input int ov_cyc,
                     input int rst_cyc, input logic [15:0] exp);
    int          bad, first_bad, nvalid, vcyc, kk;
    bit          cut;
    logic        e_rden, e_busy, e_oval, e_ovr;
    logic [8:0]  e_ptr;
    logic [7:0]  e_ca;
    logic [15:0] got;
    bad = 0; first_bad = -1; nvalid = 0; vcyc = -1; got = 16'h0;
    @(negedge clk);
    smp_valid = 1'b1;
    smp_ptr   = ptr;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      smp_valid = 1'b0;
      rst       = 1'b0;
      cut    = (rst_cyc > 0) && (c > rst_cyc);
      kk     = (c <= TAPS) ? c - 1 : TAPS - 1;
      e_rden = !cut && (c <= TAPS);
      e_busy = !cut && (c <= TAPS + 3);
      e_oval = !cut && (c == TAPS + 4);
      e_ovr  = !cut && (ov_cyc > 0) && (c == ov_cyc + 1);
      e_ptr  = cut ? 9'd0 : ptr - 9'(kk);
      e_ca   = cut ? 8'd0 : 8'(kk);
      if (rden !== e_rden || busy !== e_busy || out_valid !== e_oval || overrun !== e_ovr ||
          rdptr !== e_ptr || coef_addr !== e_ca || (cut && out_data !== 16'h0)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (out_valid === 1'b1) begin
        nvalid++;
        vcyc = c;
        got  = out_data;
      end
      if (c == ov_cyc) begin
        smp_valid = 1'b1;
        smp_ptr   = ptr + 9'd50;
      end
      if (c == rst_cyc) rst = 1'b1;
    end
    check({nm, "_ctl_bad_cycles"}, 64'(bad), 64'd0);
    if (bad != 0) $display("  %s first deviating cycle %0d", nm, first_bad);
    if (rst_cyc > 0) begin
      check({nm, "_valid_count"}, 64'(nvalid), 64'd0);
    end else begin
      check({nm, "_valid_count"}, 64'(nvalid), 64'd1);
      check({nm, "_valid_cycle"}, 64'(vcyc), 64'(TAPS + 4));
      check({nm, "_out_data"}, 64'(got), 64'(exp));
    end
  endtask

  initial begin
    vecs[0] = '{"impulse",   9'd105, 100, 16'h4000, 5,  16'h1234, 16'h091A};
    vecs[1] = '{"pos_sat",   9'd200, -1,  16'h7FFF, -1, 16'h7FFF, 16'h7FFF};
    vecs[2] = '{"neg_sat",   9'd17,  -1,  16'h8000, -1, 16'h7FFF, 16'h8000};
    vecs[3] = '{"neg_imp",   9'd105, 100, 16'hC000, 5,  16'h1234, 16'hF6E6};
    vecs[4] = '{"round_up",  9'd105, 100, 16'h0001, 5,  16'h4000, 16'h0001};
    vecs[5] = '{"round_dn",  9'd105, 100, 16'h0001, 5,  16'h3FFF, 16'h0000};
    vecs[6] = '{"wrap_imp",  9'd3,   510, 16'h2000, 5,  16'h7FFF, 16'h2000};

    rst = 1'b1; smp_valid = 1'b0; smp_ptr = 9'd0;
    load(-1, 16'h0000, -1, 16'h0000);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({rden, busy, out_valid, overrun, rdptr, coef_addr, out_data}),
          64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      load(vecs[i].sidx, vecs[i].sval, vecs[i].cidx, vecs[i].cval);
      run(vecs[i].name, vecs[i].ptr, -1, -1, vecs[i].exp);
    end

    // Constant data: 32 * 256 * 256 / 2^15 = 64.
    load(-1, 16'h0100, -1, 16'h0100);
    run("dc_sum", 9'd300, -1, -1, 16'h0040);

    load(100, 16'h4000, 5, 16'h1234);
    run("overrun_mid", 9'd105, 10, -1, 16'h091A);
    run("overrun_out", 9'd105, 36, -1, 16'h091A);
    run("reset_mid", 9'd105, -1, 15, 16'h0000);
    run("after_reset", 9'd105, -1, -1, 16'h091A);

    // Reset wins over a simultaneous strobe.
    @(negedge clk);
    rst = 1'b1; smp_valid = 1'b1; smp_ptr = 9'd105;
    @(negedge clk);
    rst = 1'b0; smp_valid = 1'b0;
    check("rst_priority_busy", 64'({busy, rden}), 64'd0);
    @(negedge clk);
    check("rst_priority_idle", 64'({busy, rden}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
